// File: rtl/demux1_8_scan_pkg.sv
// Shared definitions for the 1-to-8 scanning demultiplexer: state encoding,
// channel count and the even-parity frame check.
package demux1_8_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } state_e;

  // True when the frame bits plus the trailing parity bit hold an even number of ones.
  function automatic logic even_par_ok(input logic [NUM_CH:0] bits);
    return ~^bits;
  endfunction

endpackage

// File: rtl/demux1_8_scan_ch_counter3.sv
// 3-bit scan channel counter with synchronous clear, count enable and wrap flag.
module ch_counter3
  import demux1_8_scan_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CH_W-1:0] cnt_o,
  output logic            wrap_o
);

  logic [CH_W-1:0] cnt_q;
  logic [CH_W-1:0] cnt_d;

  // Next count: clear wins over enable; the 3-bit add wraps 7 -> 0 on its own.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 3'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i && (cnt_q == 3'd7);

endmodule

// File: rtl/demux1_8_scan.sv
// 1-to-8 demultiplexer with direct write and an 8-channel serial scan.
// Define DEMUX_PARITY_EN to append an even-parity bit after channel 7.
module demux1_8_scan
  import demux1_8_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic [CH_W-1:0]   sel,
  input  logic              wr,
  input  logic              start,
  output logic [NUM_CH-1:0] out,
  output logic [CH_W-1:0]   cur_ch,
  output logic              busy,
  output logic              done,
  output logic              par_ok
);

  state_e            state_q;
  state_e            state_d;
  logic [NUM_CH-1:0] out_q;
  logic [NUM_CH-1:0] out_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;
  logic              par_ok_q;
  logic              par_ok_d;
  logic [CH_W-1:0]   cnt_s;
  logic              wrap_s;
  logic              cnt_clr_s;
  logic              cnt_en_s;

  assign cnt_clr_s = (state_q == IDLE);
  assign cnt_en_s  = (state_q == SCAN);

  ch_counter3 u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .cnt_o  (cnt_s),
    .wrap_o (wrap_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (wrap_s) begin
`ifdef DEMUX_PARITY_EN
          state_d = PAR;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = SCAN;
        end
      end
`ifdef DEMUX_PARITY_EN
      PAR:     state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; busy/done are decoded from the next state so they are registered.
  always_comb begin
    out_d    = out_q;
    par_ok_d = par_ok_q;
    busy_d   = (state_d == SCAN) || (state_d == PAR);
    done_d   = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (!start && wr) begin
          out_d[sel] = din;
        end else begin
          out_d = out_q;
        end
      end
      SCAN: begin
        out_d[cnt_s] = din;
      end
`ifdef DEMUX_PARITY_EN
      PAR: begin
        par_ok_d = even_par_ok({out_q, din});
      end
`endif
      default: begin
        out_d    = out_q;
        par_ok_d = par_ok_q;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      par_ok_q <= 1'b1;
    end else begin
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      par_ok_q <= par_ok_d;
    end
  end

  assign out    = out_q;
  assign cur_ch = cnt_s;
  assign busy   = busy_q;
  assign done   = done_q;
  assign par_ok = par_ok_q;

endmodule

// File: tb/tb_demux1_8_scan.sv
// Self-checking bench for demux1_8_scan: directed cases plus randomized
// traffic against a frame-timing reference model.
module tb_demux1_8_scan;

`ifdef DEMUX_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic [2:0] sel;
  logic       wr;
  logic       start;
  logic [7:0] out;
  logic [2:0] cur_ch;
  logic       busy;
  logic       done;
  logic       par_ok;

  int total = 0;
  int bad   = 0;

  // Reference model: edge count, edge at which the current frame started (-1 none).
  int         e;
  int         fs;
  logic [7:0] m_out;
  logic       m_par;

  demux1_8_scan dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .sel    (sel),
    .wr     (wr),
    .start  (start),
    .out    (out),
    .cur_ch (cur_ch),
    .busy   (busy),
    .done   (done),
    .par_ok (par_ok)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    fs    = -1;
    m_out = 8'h00;
    m_par = 1'b1;
  endtask

  // Apply the inputs sampled at one rising edge to the model.
  task automatic model_edge(input logic d, input logic [2:0] s, input logic w, input logic st);
    int k;
    e++;
    if (fs < 0 || e >= fs + FLEN + 2) begin
      fs = -1;
      if (st) fs = e;
      else if (w) m_out[s] = d;
    end else begin
      k = e - fs;
      if (k >= 1 && k <= 8) m_out[k-1] = d;
      else if (k == 9 && FLEN == 9) m_par = ~^{m_out, d};
    end
  endtask

  task automatic check_all();
    int k;
    int eb;
    int ed;
    int ec;
    eb = 0; ed = 0; ec = 0;
    if (fs >= 0) begin
      k  = e - fs;
      eb = (k < FLEN) ? 1 : 0;
      ed = (k == FLEN) ? 1 : 0;
      ec = (k < 8) ? k : 0;
    end
    check_eq("out",    out,    m_out);
    check_eq("cur_ch", cur_ch, ec);
    check_eq("busy",   busy,   eb);
    check_eq("done",   done,   ed);
    check_eq("par_ok", par_ok, m_par);
  endtask

  task automatic step(input logic d, input logic [2:0] s, input logic w, input logic st);
    din = d; sel = s; wr = w; start = st;
    @(posedge clk);
    model_edge(d, s, w, st);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_out",  out,    8'h00);
    check_eq("rst_busy", busy,   1'b0);
    check_eq("rst_done", done,   1'b0);
    check_eq("rst_cur",  cur_ch, 3'd0);
    check_eq("rst_par",  par_ok, 1'b1);
    @(negedge clk);
    din = 1'b0; sel = 3'd0; wr = 1'b0; start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    int done_cnt;
    int done_at;
    int start_at;

    pat = 8'h4D;
    rst_n = 1'b0; din = 1'b0; sel = 3'd0; wr = 1'b0; start = 1'b0;
    e = 0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Direct write to channel 5.
    step(1'b1, 3'd5, 1'b1, 1'b0);
    check_eq("wr5_out", out, 8'h20);

    // Scan 1,0,1,1,0,0,1,0 into channels 0..7 with wr noise on sel=2.
    step(1'b0, 3'd0, 1'b0, 1'b1);
    start_at = e;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < 8; i++) begin
      step(pat[i], 3'd2, 1'b1, 1'b0);
    end
`ifdef DEMUX_PARITY_EN
    step(1'b0, 3'd0, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 4; i++) begin
      if (done) begin
        done_cnt++;
        done_at = e;
      end
      step(1'b0, 3'd0, 1'b0, 1'b1 && (i == 0));
    end
    check_eq("scan_out", out, 8'h4D);
    check_eq("done_cnt", done_cnt, 1);
    check_eq("done_lat", done_at - start_at, FLEN);

`ifdef DEMUX_PARITY_EN
    // Parity 0 over four ones is even -> ok; parity 1 -> not ok.
    for (int p = 0; p < 2; p++) begin
      step(1'b0, 3'd0, 1'b0, 1'b1);
      start_at = e;
      for (int i = 0; i < 8; i++) step(pat[i], 3'd0, 1'b0, 1'b0);
      step(p[0], 3'd0, 1'b0, 1'b0);
      check_eq("par_done_lat", (done === 1'b1) ? (e - start_at) : -1, 9);
      check_eq("par_ok_dir", par_ok, (p == 0) ? 1'b1 : 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b0);
    end
`endif

    // Start and wr together after reset: no write, scan starts at channel 0.
    async_reset();
    step(1'b1, 3'd0, 1'b1, 1'b1);
    check_eq("sw_out", out, 8'h00);
    check_eq("sw_cur", cur_ch, 3'd0);
    check_eq("sw_busy", busy, 1'b1);

    // Reset while cur_ch is 4 aborts the frame with no done pulse.
    for (int i = 0; i < 4; i++) step(1'b1, 3'd0, 1'b0, 1'b0);
    check_eq("mid_cur", cur_ch, 3'd4);
    async_reset();
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 3'd0, 1'b0, 1'b0);
      if (done) done_cnt++;
    end
    check_eq("abort_done", done_cnt, 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom), 3'($urandom), 1'($urandom),
             ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
